// File: rtl/fight_action_sequencer.sv
// fight_action_sequencer
// Producer side of the fighting-game action interface. Synchronizes and
// debounces both players' commit buttons, latches each player's action
// switches on commit, and once both players have committed (or the second
// player times out) presents action1/action2 with setup time, strikes
// actionEnable for a fixed number of cycles, then holds the codes.
module fight_action_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETUP_CYCLES    = 2,
  parameter int unsigned ENABLE_CYCLES   = 2,
  parameter int unsigned HOLD_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter logic [2:0]  DEFAULT_ACTION  = 3'b000
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic [2:0] p1Switch,
  input  logic       p1Button,
  input  logic [2:0] p2Switch,
  input  logic       p2Button,
  input  logic       gameOver,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       p1Ready,
  output logic       p2Ready,
  output logic       busy
);

  // Counter width: enough to count to max(param,2) with one spare bit.
  function automatic int unsigned cnt_w(input int unsigned v);
    return $clog2((v < 2) ? 2 : v) + 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int unsigned DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int unsigned PH_W = cnt_w(max3(SETUP_CYCLES, ENABLE_CYCLES, HOLD_CYCLES));
  localparam int unsigned TM_W = cnt_w(TIMEOUT_CYCLES);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] EN_LAST    = PH_W'(ENABLE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(HOLD_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST    = TM_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_SETUP,
    S_FIRE,
    S_HOLD
  } state_t;

  // Index 0 is player 1, index 1 is player 2 throughout.
  logic [1:0]            w_btn_in;
  logic [1:0][2:0]       w_sw_in;
  logic [1:0]            r_btn_s1, r_btn_s2;
  logic [1:0][2:0]       r_sw_s1, r_sw_s2;
  logic [1:0]            r_db;
  logic [1:0][DB_W-1:0]  r_db_cnt;
  logic [1:0]            w_db_flip;
  logic [1:0]            w_commit;
  logic [1:0]            w_commit_ok;
  logic [1:0]            w_ready_eff;
  logic [1:0][2:0]       w_pend_eff;
  logic [1:0]            r_ready;
  logic [1:0][2:0]       r_pend;
  logic [1:0][2:0]       r_action;

  state_t                r_state, w_state_nxt;
  logic [TM_W-1:0]       r_timer;
  logic [PH_W-1:0]       r_phase;
  logic                  w_open;
  logic                  w_load;
  logic                  w_timeout;
  logic                  w_clear_ready;
  logic                  w_enable;
  logic                  w_busy;

  assign w_btn_in   = {p2Button, p1Button};
  assign w_sw_in[0] = p1Switch;
  assign w_sw_in[1] = p2Switch;

  // Two-flop synchronizers for every asynchronous board input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= w_btn_in;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= w_sw_in;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Debounce decode: flip when the input has disagreed long enough; a rising
  // flip is a commit, gated to the rounds-open states when gameOver is low.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_db_flip   = '0;
    w_commit    = '0;
    w_commit_ok = '0;
    w_ready_eff = '0;
    w_pend_eff  = '0;
    w_open      = (r_state == S_IDLE) || (r_state == S_COLLECT);
    for (int i = 0; i < 2; i++) begin
      w_db_flip[i]   = (r_btn_s2[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST);
      w_commit[i]    = w_db_flip[i] && !r_db[i];
      w_commit_ok[i] = w_commit[i] && w_open && !gameOver;
      w_ready_eff[i] = r_ready[i] || w_commit_ok[i];
      w_pend_eff[i]  = w_commit_ok[i] ? r_sw_s2[i] : r_pend[i];
    end
  end

  // Debounce counters: count consecutive disagreement, restart on any match.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_db     <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_flip[i]) begin
          r_db[i]     <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Round FSM next state and decoded outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_timeout     = 1'b0;
    w_clear_ready = 1'b0;
    w_enable      = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!gameOver) begin
          if (&w_ready_eff) begin
            w_state_nxt = S_SETUP;
            w_load      = 1'b1;
          end else if (|w_ready_eff) begin
            w_state_nxt = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (gameOver) begin
          w_state_nxt = S_IDLE;
        end else if (&w_ready_eff) begin
          w_state_nxt = S_SETUP;
          w_load      = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (r_timer == TM_LAST)) begin
          w_state_nxt = S_SETUP;
          w_load      = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      S_SETUP: begin
        w_busy = 1'b1;
        if (r_phase == SETUP_LAST) w_state_nxt = S_FIRE;
      end
      S_FIRE: begin
        w_busy   = 1'b1;
        w_enable = 1'b1;
        if (r_phase == EN_LAST) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_busy = 1'b1;
        if (r_phase == HOLD_LAST) begin
          w_state_nxt   = S_IDLE;
          w_clear_ready = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus the collect timer and the shared phase counter.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_COLLECT) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + TM_W'(1);
      end
      if (w_state_nxt != r_state) begin
        r_phase <= '0;
      end else if (w_busy) begin
        r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  // Pending action registers and ready flags.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_ready <= '0;
      r_pend  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_clear_ready || (w_open && gameOver)) begin
          r_ready[i] <= 1'b0;
        end else if (w_commit_ok[i]) begin
          r_ready[i] <= 1'b1;
          r_pend[i]  <= r_sw_s2[i];
        end else if (w_timeout && !r_ready[i]) begin
          r_pend[i]  <= DEFAULT_ACTION;
        end
      end
    end
  end

  // Action codes change only on the edge that enters SETUP.
  always_ff @(posedge clk) begin
    if (resetGame) begin
      r_action <= '0;
    end else if (w_load) begin
      for (int i = 0; i < 2; i++) begin
        r_action[i] <= w_ready_eff[i] ? w_pend_eff[i] : DEFAULT_ACTION;
      end
    end
  end

  assign action1      = r_action[0];
  assign action2      = r_action[1];
  assign actionEnable = w_enable;
  assign p1Ready      = r_ready[0];
  assign p2Ready      = r_ready[1];
  assign busy         = w_busy;

endmodule
